pc_sequencer: RTL
=================

# pc_sequencer

Parametrised program-counter sequencer for the RISC core's fetch stage. It holds the architectural PC and computes the next PC each cycle from a command: sequential, relative branch, absolute jump, call, or return. It adds stall, halt/resume control and a small circular return-address stack (RAS). Its output drives instruction-memory addressing.

## Interface
Parameters:
- WIDTH, 32: PC and address width in bits.
- RESET_VECTOR, 0: PC value loaded on reset.
- STEP, 4: sequential increment in bytes; power of two, at least 1.
- RAS_DEPTH, 4: return-stack entries; power of two, at least 2.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clock.
- stall  in  1  hold the PC this cycle; cmd is ignored.
- halt_req  in  1  enter HALTED.
- resume  in  1  leave HALTED.
- cmd  in  3  0 SEQ, 1 BRANCH, 2 JUMP, 3 CALL, 4 RET; values 5-7 behave as SEQ.
- operand  in  WIDTH  signed offset for BRANCH; absolute target for JUMP and CALL.
- pc_out  out  WIDTH  current PC (registered).
- halted  out  1  high while in HALTED.
- ras_count  out  $clog2(RAS_DEPTH)+1  number of valid RAS entries.
- ret_underflow  out  1  one-cycle pulse: RET was issued with the RAS empty.
- misaligned  out  1  one-cycle pulse: the PC just loaded has nonzero low log2(STEP) bits.

## Operation
- States: RUN and HALTED.
  - RUN → HALTED when halt_req=1.
  - HALTED → RUN when resume=1 and halt_req=0.
- Priority, highest first: reset, then halt_req or HALTED state, then stall, then cmd.
- The PC holds while HALTED, while stalled, and in the cycle halt_req is taken. The RAS is untouched in all three cases.
- Next PC in RUN when not stalled (all arithmetic modulo 2^WIDTH; carries are discarded):
  - SEQ: pc+STEP.
  - BRANCH: pc+operand, two's complement.
  - JUMP: operand.
  - CALL: operand; pushes pc+STEP onto the RAS.
  - RET: pops the top of the RAS. If the RAS is empty, next PC is pc+STEP, ret_underflow pulses, and ras_count stays 0.
- RAS is circular:
  - A CALL with the RAS full overwrites the oldest entry; ras_count stays RAS_DEPTH.
  - A pop returns the most recent surviving push.
- misaligned pulses in the cycle after a misaligned PC is loaded. The PC is still taken unmodified.
- Reset:
  - pc_out=RESET_VECTOR, state=RUN, ras_count=0, halted=0, ret_underflow=0, misaligned=0.
  - RAS contents are don't-care.
  - Reset asserted mid-halt or mid-stall wins unconditionally.

## Timing
- Inputs are sampled on the rising edge; the resulting PC appears on pc_out in the same edge's output, i.e. one cycle of latency.
- halted rises on the edge that samples halt_req and falls on the edge that samples resume.
- The first PC advance after resume occurs on the edge after the one that cleared halted. cmd is ignored on the resume edge.
- ret_underflow and misaligned are registered and each stays high for exactly one cycle per event.
- halt_req and resume high together: halt_req wins; the block stays in or enters HALTED.
- The first reset-low edge executes cmd normally. Back-to-back CALL/RET is supported every cycle with no bubbles.

## Structure
- Shared package pc_pkg holds:
  - cmd encodings: CMD_SEQ, CMD_BRANCH, CMD_JUMP, CMD_CALL, CMD_RET.
  - state encodings: ST_RUN, ST_HALTED.
- Sub-module return_stack, parametrised by WIDTH and RAS_DEPTH:
  - inputs: push, pop, push_data.
  - outputs: top, count, empty.
  - implements circular overwrite-on-full.
- The top level contains the FSM, next-PC mux, adder and pulse registers.

## Test plan
- Reset with RESET_VECTOR=32'h100, then 3 SEQ cycles → pc_out 100, 104, 108, 10C; ras_count=0.
- PC=0x200, BRANCH operand=32'hFFFF_FFF0 → PC=0x1F0. JUMP 0x1002 → PC=0x1002; misaligned pulses for one cycle.
- PC=0x40, CALL 0x800 → PC=0x800, ras_count=1. Then SEQ, then RET → PC=0x44, ras_count=0.
- RAS_DEPTH=4: five nested CALLs from 0x0, 0x100, 0x200, 0x300, 0x400, then five RETs → pops 0x404, 0x304, 0x204, 0x104; fifth RET gives pc+4 and pulses ret_underflow.
- stall=1 with cmd=JUMP → PC unchanged. halt_req during CALL → PC and ras_count unchanged, halted=1. Hold 3 cycles, then resume → next cycle halted=0; the following SEQ advances the PC by 4.
- reset asserted while halted with ras_count=2 → pc_out=RESET_VECTOR, halted=0, ras_count=0 on the next edge.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared encodings for the fetch-stage PC sequencer: command codes and FSM states.
package pc_pkg;

   typedef enum logic [2:0] {
      CMD_SEQ    = 3'd0,
      CMD_BRANCH = 3'd1,
      CMD_JUMP   = 3'd2,
      CMD_CALL   = 3'd3,
      CMD_RET    = 3'd4
   } cmd_e;

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } state_e;

endpackage

// File: rtl/pc_sequencer_return_stack.sv
// Circular return-address stack; a push while full overwrites the oldest entry.
module return_stack #(
   parameter int WIDTH     = 32,
   parameter int RAS_DEPTH = 4
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         push,
   input  logic                         pop,
   input  logic [WIDTH-1:0]             push_data,
   output logic [WIDTH-1:0]             top,
   output logic [$clog2(RAS_DEPTH):0]   count,
   output logic                         empty
);
   import pc_pkg::*;

   localparam int PTR_W = $clog2(RAS_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [RAS_DEPTH];
   logic [WIDTH-1:0] mem_d [RAS_DEPTH];
   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   // ptr_q is the next write slot; the top of stack sits one below it.
   always_comb begin
      mem_d   = mem_q;
      ptr_d   = ptr_q;
      count_d = count_q;
      if (push) begin
         mem_d[ptr_q] = push_data;
         ptr_d        = ptr_q + PTR_W'(1);
         if (count_q != CNT_W'(RAS_DEPTH))
            count_d = count_q + CNT_W'(1);
      end else if (pop && (count_q != '0)) begin
         ptr_d   = ptr_q - PTR_W'(1);
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         ptr_q   <= '0;
         count_q <= '0;
      end else begin
         ptr_q   <= ptr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clock) begin
      mem_q <= mem_d;
   end

   assign top   = mem_q[ptr_q - PTR_W'(1)];
   assign count = count_q;
   assign empty = (count_q == '0);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: run/halt FSM, next-PC mux, call/return stack and event pulses.
module pc_sequencer #(
   parameter int              WIDTH        = 32,
   parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
   parameter int              STEP         = 4,
   parameter int              RAS_DEPTH    = 4
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        stall,
   input  logic                        halt_req,
   input  logic                        resume,
   input  logic [2:0]                  cmd,
   input  logic [WIDTH-1:0]            operand,
   output logic [WIDTH-1:0]            pc_out,
   output logic                        halted,
   output logic [$clog2(RAS_DEPTH):0]  ras_count,
   output logic                        ret_underflow,
   output logic                        misaligned
);
   import pc_pkg::*;

   localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
   localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(STEP - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic             underflow_q, underflow_d;
   logic             misaligned_q, misaligned_d;
   logic             push, pop, ras_empty;
   logic [WIDTH-1:0] ras_top, pc_seq;

   assign pc_seq = pc_q + STEP_W;

   // Halt takes priority over stall; the resume edge only leaves HALTED, it never advances.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      underflow_d  = 1'b0;
      misaligned_d = 1'b0;
      push         = 1'b0;
      pop          = 1'b0;
      if (state_q == ST_RUN) begin
         if (halt_req) begin
            state_d = ST_HALTED;
         end else if (!stall) begin
            case (cmd)
               CMD_BRANCH: pc_d = pc_q + operand;
               CMD_JUMP:   pc_d = operand;
               CMD_CALL: begin
                  pc_d = operand;
                  push = 1'b1;
               end
               CMD_RET: begin
                  if (ras_empty) begin
                     pc_d        = pc_seq;
                     underflow_d = 1'b1;
                  end else begin
                     pc_d = ras_top;
                     pop  = 1'b1;
                  end
               end
               default:    pc_d = pc_seq;
            endcase
            misaligned_d = |(pc_d & ALIGN_MASK);
         end
      end else if (resume && !halt_req) begin
         state_d = ST_RUN;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= ST_RUN;
         pc_q         <= RESET_VECTOR;
         underflow_q  <= 1'b0;
         misaligned_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         underflow_q  <= underflow_d;
         misaligned_q <= misaligned_d;
      end
   end

   return_stack #(
      .WIDTH     (WIDTH),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clock     (clock),
      .reset     (reset),
      .push      (push),
      .pop       (pop),
      .push_data (pc_seq),
      .top       (ras_top),
      .count     (ras_count),
      .empty     (ras_empty)
   );

   assign pc_out        = pc_q;
   assign halted        = (state_q == ST_HALTED);
   assign ret_underflow = underflow_q;
   assign misaligned    = misaligned_q;

endmodule
